// File: rtl/lab_readout_sched.sv
// ---------------------------------------------------------------------------
// lab_readout_sched
//   Round-robin readout scheduler for NUM_LAB LAB digitiser channels plus the
//   host read path into the per-LAB readout RAMs.
//
//   A digitize request marks a LAB pending. The scheduler grants one pending
//   LAB at a time, pulses its readout start, and waits for that LAB's
//   completion pulse. A LAB's data-valid flag is raised on completion unless
//   a newer digitize request arrived while it was being read out.
//
// Ports
//   clk_i           rising-edge clock
//   rst_n_i         asynchronous active-low reset
//   digitize_i      per-LAB one-cycle digitize request
//   readout_o       per-LAB one-cycle readout start (registered)
//   readout_done_i  per-LAB one-cycle readout complete
//   busy_o          scheduler not idle
//   active_o        index of the granted LAB
//   done_vec_o      per-LAB data-valid flags
//   addr_i          host address {lab_select, ram_address}
//   ram_addr_o      shared RAM read address (combinational from addr_i)
//   ram_dat_i       flattened RAM read data, LAB i at [i*DAT_W +: DAT_W]
//   dat_o           host read data, two cycles after addr_i
//   done_o          data-valid flag of the host-selected LAB, one cycle after
//   err_o           sticky per-LAB readout timeout flags
//
// Build option
//   LAB_SCHED_TIMEOUT_EN  when defined, a watchdog aborts a readout that has
//                         waited TIMEOUT_CYC cycles and flags err_o; when not
//                         defined the wait is unbounded and err_o is 0.
// ---------------------------------------------------------------------------
module lab_readout_sched #(
    parameter int unsigned NUM_LAB     = 4,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned RAM_ADDR_W  = 11,
    parameter int unsigned DAT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [NUM_LAB-1:0]          digitize_i,
    output logic [NUM_LAB-1:0]          readout_o,
    input  logic [NUM_LAB-1:0]          readout_done_i,
    output logic                        busy_o,
    output logic [SEL_W-1:0]            active_o,
    output logic [NUM_LAB-1:0]          done_vec_o,
    input  logic [SEL_W+RAM_ADDR_W-1:0] addr_i,
    output logic [RAM_ADDR_W-1:0]       ram_addr_o,
    input  logic [NUM_LAB*DAT_W-1:0]    ram_dat_i,
    output logic [DAT_W-1:0]            dat_o,
    output logic                        done_o,
    output logic [NUM_LAB-1:0]          err_o
);

    if (NUM_LAB < 1 || NUM_LAB > 8 || (1 << SEL_W) < NUM_LAB || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("lab_readout_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_q;
    logic [SEL_W-1:0]     active_q;
    logic [SEL_W-1:0]     last_q;
    logic [NUM_LAB-1:0]   pending_q;
    logic [NUM_LAB-1:0]   done_q;
    logic [NUM_LAB-1:0]   readout_q;

    logic [SEL_W-1:0]     win_sel;
    logic [NUM_LAB-1:0]   win_oh;
    logic [NUM_LAB-1:0]   act_oh;
    logic                 done_hit;
    logic [NUM_LAB-1:0]   pend_clr;
    logic [NUM_LAB-1:0]   done_set;
    int unsigned          ls_u;
    int unsigned          dist_u;
    int unsigned          best_u;

    // Host path
    logic [SEL_W-1:0]     host_sel;
    logic [SEL_W-1:0]     sel_d_q;
    logic                 host_done_nxt;
    logic [DAT_W-1:0]     host_dat_nxt;
    logic                 done_o_q;
    logic [DAT_W-1:0]     dat_q;

`ifdef LAB_SCHED_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMR_W-1:0]     tmr_q;
    logic [NUM_LAB-1:0]   err_q;
    assign err_o = err_q;
`else
    assign err_o = '0;
`endif

    // Round-robin pick: rank each pending LAB by its distance after the
    // last served LAB, so last_q+1 has the highest priority and last_q the
    // lowest. Avoids a run-time modulo on a dynamic index.
    always_comb begin
        win_sel = '0;
        best_u  = NUM_LAB;
        dist_u  = 0;
        ls_u    = 32'(last_q);
        for (int unsigned i = 0; i < NUM_LAB; i++) begin
            dist_u = (i > ls_u) ? (i - ls_u - 1) : (i + NUM_LAB - ls_u - 1);
            if (pending_q[i] && dist_u < best_u) begin
                best_u  = dist_u;
                win_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        win_oh = '0;
        act_oh = '0;
        for (int unsigned i = 0; i < NUM_LAB; i++) begin
            win_oh[i] = (win_sel == SEL_W'(i));
            act_oh[i] = (active_q == SEL_W'(i));
        end
    end

    // Completion pulses of LABs other than the granted one are masked out.
    assign done_hit = |(readout_done_i & act_oh);

    // Pending drops on the edge that launches the readout pulse; a request
    // arriving in that same cycle re-arms it through the OR below.
    assign pend_clr = (state_q == ST_IDLE && (|pending_q)) ? win_oh : '0;
    assign done_set = (state_q == ST_WAIT && done_hit) ? (act_oh & ~pending_q) : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            active_q  <= '0;
            last_q    <= SEL_W'(NUM_LAB - 1);
            pending_q <= '0;
            done_q    <= '0;
            readout_q <= '0;
`ifdef LAB_SCHED_TIMEOUT_EN
            tmr_q     <= '0;
            err_q     <= '0;
`endif
        end else begin
            pending_q <= (pending_q & ~pend_clr) | digitize_i;
            done_q    <= (done_q | done_set) & ~digitize_i;
            readout_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|pending_q) begin
                        active_q  <= win_sel;
                        readout_q <= win_oh;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
`ifdef LAB_SCHED_TIMEOUT_EN
                    tmr_q   <= '0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_hit) begin
                        last_q  <= active_q;
                        state_q <= ST_IDLE;
                    end
`ifdef LAB_SCHED_TIMEOUT_EN
                    else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                        err_q   <= err_q | act_oh;
                        last_q  <= active_q;
                        state_q <= ST_IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign readout_o  = readout_q;
    assign active_o   = active_q;
    assign done_vec_o = done_q;
    assign busy_o     = (state_q != ST_IDLE);

    // Host read path: the RAM address goes straight out; the LAB select is
    // delayed one cycle to line up with the RAM's registered read data.
    assign ram_addr_o = addr_i[RAM_ADDR_W-1:0];
    assign host_sel   = addr_i[SEL_W+RAM_ADDR_W-1 -: SEL_W];

    // Selects with no matching LAB fall through to the zero defaults.
    always_comb begin
        host_done_nxt = 1'b0;
        host_dat_nxt  = '0;
        for (int unsigned i = 0; i < NUM_LAB; i++) begin
            if (host_sel == SEL_W'(i)) begin
                host_done_nxt = done_q[i];
            end
            if (sel_d_q == SEL_W'(i)) begin
                host_dat_nxt = ram_dat_i[i*DAT_W +: DAT_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_d_q  <= '0;
            done_o_q <= 1'b0;
            dat_q    <= '0;
        end else begin
            sel_d_q  <= host_sel;
            done_o_q <= host_done_nxt;
            dat_q    <= host_dat_nxt;
        end
    end

    assign done_o = done_o_q;
    assign dat_o  = dat_q;

endmodule

// File: doc/lab_readout_sched.md
LAB_READOUT_SCHED -- requirements
Module: lab_readout_sched

Interface
REQ-001 Parameter NUM_LAB, default 4, is the number of LAB channels served (1..8).
REQ-002 Parameter SEL_W, default 2, is the LAB-select width; it SHALL satisfy 2**SEL_W >= NUM_LAB.
REQ-003 Parameter RAM_ADDR_W, default 11, is the per-LAB readout RAM address width.
REQ-004 Parameter DAT_W, default 32, is the host data width.
REQ-005 Parameter TIMEOUT_CYC, default 65535, is the readout watchdog limit in clk_i cycles (used only under REQ-031).
REQ-006 Port clk_i, input, 1, the only clock; all logic is rising-edge.
REQ-007 Port rst_n_i, input, 1, reset: asynchronous, active-low.
REQ-008 Port digitize_i, input, NUM_LAB, one-cycle digitize-request pulse per LAB.
REQ-009 Port readout_o, output, NUM_LAB, one-cycle readout-start pulse to LAB controller i.
REQ-010 Port readout_done_i, input, NUM_LAB, one-cycle readout-complete pulse from LAB controller i.
REQ-011 Port busy_o, output, 1, high when state is not IDLE.
REQ-012 Port active_o, output, SEL_W, index of the LAB currently granted.
REQ-013 Port done_vec_o, output, NUM_LAB, per-LAB data-valid flags.
REQ-014 Port addr_i, input, SEL_W+RAM_ADDR_W, host address; upper SEL_W bits select the LAB.
REQ-015 Port ram_addr_o, output, RAM_ADDR_W, shared read address to all LAB RAMs (1-cycle read latency).
REQ-016 Port ram_dat_i, input, NUM_LAB*DAT_W, flattened RAM read data, LAB i at bits [i*DAT_W +: DAT_W].
REQ-017 Port dat_o, output, DAT_W, host read data.
REQ-018 Port done_o, output, 1, done flag of the host-selected LAB.
REQ-019 Port err_o, output, NUM_LAB, sticky per-LAB timeout flags.

Function
REQ-020 pending[i] SHALL set on digitize_i[i] and clear on the cycle readout_o[i] is asserted; a simultaneous digitize_i[i] keeps pending[i] set.
REQ-021 FSM states IDLE, START, WAIT; IDLE -> START when any pending bit is set, latching the winner into active_o.
REQ-022 Arbitration SHALL be round-robin: search begins at (last_served+1) mod NUM_LAB.
REQ-023 START SHALL assert readout_o[active] for exactly one cycle, then go to WAIT.
REQ-024 WAIT -> IDLE on readout_done_i[active]; last_served <= active; readout_done_i of non-active LABs is ignored.
REQ-025 done[i] SHALL clear on digitize_i[i]; it SHALL set on completion of i only if pending[i] is 0; clear wins over set in the same cycle.
REQ-026 ram_addr_o SHALL equal addr_i[RAM_ADDR_W-1:0] combinationally.
REQ-027 dat_o SHALL be registered, valid 2 cycles after addr_i, selecting ram_dat_i by the LAB select delayed 1 cycle.
REQ-028 done_o SHALL be registered, 1 cycle after addr_i.
REQ-029 LAB select >= NUM_LAB SHALL give dat_o = 0 and done_o = 0.

Reset
REQ-030 On rst_n_i low: state IDLE, pending/done/err/readout_o = 0, dat_o = 0, done_o = 0, active_o = 0, last_served = NUM_LAB-1 (LAB 0 has first priority); an in-flight readout is abandoned, and no readout_o pulse follows reset release without a new digitize_i.

Configuration
REQ-031 With LAB_SCHED_TIMEOUT_EN defined, a counter SHALL run in WAIT; on reaching TIMEOUT_CYC, err_o[active] sets, done stays 0, FSM returns to IDLE, last_served advances.
REQ-032 err_o SHALL clear only on reset.
REQ-033 Without LAB_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely, and err_o SHALL be constant 0.

Verification
REQ-034 digitize_i=4'b0001 -> readout_o[0] pulses 2 cycles later; readout_done_i[0] -> done_vec_o=4'b0001, busy_o=0.
REQ-035 digitize_i=4'b1111 in one cycle -> readout_o pulses in order LAB0, LAB1, LAB2, LAB3, each after the prior done.
REQ-036 Fill RAM2 addr 5 with 0xDEADBEEF, then set addr_i={2'd2,11'd5} -> dat_o=0xDEADBEEF two cycles later, and done_o reflects done[2] one cycle later.
REQ-037 Re-assert digitize_i[1] during WAIT on LAB1 -> done[1] stays 0 at completion; a second readout_o[1] is issued.
REQ-038 rst_n_i low mid-WAIT, asynchronous to clk_i -> all outputs 0 immediately; no readout_o after release.
REQ-039 With LAB_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16: no readout_done_i -> err_o[active]=1 after 16 WAIT cycles, FSM in IDLE, next pending LAB served.
